// File: rtl/adler32_chk.sv
// Adler-32 checker: accumulates {b,a} over a word stream and compares it with the zlib trailer.
// Optional ADLER32_CHK_PARTIAL_EN: honour bytes_i on the last word to accumulate a partial word.
module adler32_chk #(
   parameter int DATA_WD = 32,
   parameter int MOD_VAL = 65521
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start_i,
   input  logic               val_i,
   input  logic [DATA_WD-1:0] dat_i,
   input  logic               lst_i,
   input  logic [1:0]         bytes_i,
   input  logic               chk_val_i,
   input  logic [DATA_WD-1:0] chk_dat_i,
   output logic               val_o,
   output logic               done_o,
   output logic               err_o,
   output logic [DATA_WD-1:0] dat_o
);

   typedef enum logic [1:0] {IDLE, ACC, CMP, DONE} state_t;

   state_t             state_q, state_d;
   logic [15:0]        a_q, a_d, b_q, b_d;
   logic [DATA_WD-1:0] exp_q, exp_d;
   logic               data_done_q, data_done_d;
   logic               chk_got_q, chk_got_d;
   logic               val_o_q, val_o_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic [3:0]         byte_en;
   logic [15:0]        a_w, b_w;

`ifdef ADLER32_CHK_PARTIAL_EN
   // Bytes past bytes_i on the last word are padding and must not be summed.
   always_comb begin
      byte_en = '1;
      for (int k = 0; k < 4; k++)
         byte_en[k] = !lst_i || (2'(k) <= bytes_i);
   end
`else
   logic unused_bytes;
   assign unused_bytes = ^bytes_i;
   assign byte_en      = '1;
`endif

   // Four chained byte updates; a,b stay below MOD_VAL so one subtract per step suffices.
   always_comb begin : byte_chain
      logic [16:0] sa, sb;
      sa  = '0;
      sb  = '0;
      a_w = a_q;
      b_w = b_q;
      for (int k = 0; k < 4; k++) begin
         sa = {1'b0, a_w} + {9'd0, dat_i[DATA_WD-1-8*k -: 8]};
         if (sa >= 17'(MOD_VAL)) sa = sa - 17'(MOD_VAL);
         sb = {1'b0, b_w} + {1'b0, sa[15:0]};
         if (sb >= 17'(MOD_VAL)) sb = sb - 17'(MOD_VAL);
         if (byte_en[k]) begin
            a_w = sa[15:0];
            b_w = sb[15:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      exp_d       = exp_q;
      data_done_d = data_done_q;
      chk_got_d   = chk_got_q;
      val_o_d     = 1'b0;
      done_d      = done_q;
      err_d       = err_q;
      if (start_i) begin
         state_d     = ACC;
         a_d         = 16'd1;
         b_d         = 16'd0;
         data_done_d = 1'b0;
         chk_got_d   = 1'b0;
         done_d      = 1'b0;
         err_d       = 1'b0;
      end else begin
         case (state_q)
            ACC: begin
               if (val_i && !data_done_q) begin
                  a_d = a_w;
                  b_d = b_w;
                  if (lst_i) data_done_d = 1'b1;
               end
               if (chk_val_i) begin
                  exp_d     = chk_dat_i;
                  chk_got_d = 1'b1;
               end
               if (data_done_d && chk_got_d) state_d = CMP;
            end
            CMP: begin
               val_o_d = 1'b1;
               done_d  = 1'b1;
               err_d   = ({b_q, a_q} != exp_q);
               state_d = DONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         a_q         <= 16'd1;
         b_q         <= 16'd0;
         exp_q       <= '0;
         data_done_q <= 1'b0;
         chk_got_q   <= 1'b0;
         val_o_q     <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         exp_q       <= exp_d;
         data_done_q <= data_done_d;
         chk_got_q   <= chk_got_d;
         val_o_q     <= val_o_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign val_o  = val_o_q;
   assign done_o = done_q;
   assign err_o  = err_q;
   assign dat_o  = {b_q, a_q};

endmodule

// File: tb/tb_adler32_chk.sv
// Scoreboarded bench for adler32_chk: byte-level Adler-32 reference, randomized streams.
module tb_adler32_chk;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start_i, val_i, lst_i, chk_val_i;
   logic [31:0] dat_i, chk_dat_i;
   logic [1:0]  bytes_i;
   logic        val_o, done_o, err_o;
   logic [31:0] dat_o;

   int n_chk = 0;
   int n_err = 0;
   logic [32:0] sb_q[$];
   logic inv_bad = 1'b0;

   adler32_chk dut (
      .clk(clk), .rstn(rstn), .start_i(start_i), .val_i(val_i), .dat_i(dat_i),
      .lst_i(lst_i), .bytes_i(bytes_i), .chk_val_i(chk_val_i), .chk_dat_i(chk_dat_i),
      .val_o(val_o), .done_o(done_o), .err_o(err_o), .dat_o(dat_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] adler_ref(input byte unsigned bq[$]);
      int unsigned a = 1, b = 0;
      foreach (bq[i]) begin
         a = (a + bq[i]) % 65521;
         b = (b + a) % 65521;
      end
      return {b[15:0], a[15:0]};
   endfunction

   // Scoreboard monitor: every val_o pulse must match the oldest pending stream.
   always @(negedge clk) begin
      if (rstn) begin
         if (dat_o[15:0] >= 16'd65521 || dat_o[31:16] >= 16'd65521) inv_bad <= 1'b1;
         if (val_o) begin
            if (sb_q.size() == 0) begin
               check("unexpected_val_o", 32'd1, 32'd0);
            end else begin
               logic [32:0] e;
               e = sb_q.pop_front();
               check("sb_dat", dat_o, e[31:0]);
               check("sb_err", {31'd0, err_o}, {31'd0, e[32]});
               check("sb_done", {31'd0, done_o}, 32'd1);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      start_i = 0; val_i = 0; lst_i = 0; chk_val_i = 0;
      dat_i = 0; chk_dat_i = 0; bytes_i = 2'd3;
   endtask

   task automatic do_start();
      start_i = 1; tick(); start_i = 0;
   endtask

   // chk_pos: 0 = before data (after a stale value to be overwritten), 1 = with last word,
   // 2 = after last word, preceded by an extra word that must be ignored.
   task automatic run_stream(input logic [31:0] w[$], input logic [1:0] lastb,
                             input logic [31:0] chk, input int chk_pos, input bit gaps);
      byte unsigned bq[$];
      logic [31:0] expd;
      int nb;
      bit seen;
      for (int i = 0; i < w.size(); i++) begin
         nb = 4;
`ifdef ADLER32_CHK_PARTIAL_EN
         if (i == w.size() - 1) nb = int'(lastb) + 1;
`endif
         for (int k = 0; k < nb; k++) bq.push_back(w[i][31-8*k -: 8]);
      end
      expd = adler_ref(bq);
      sb_q.push_back({(expd != chk), expd});
      do_start();
      if (chk_pos == 0) begin
         chk_val_i = 1; chk_dat_i = ~chk; tick();
         chk_dat_i = chk; tick(); chk_val_i = 0;
      end
      for (int i = 0; i < w.size(); i++) begin
         val_i = 1; dat_i = w[i]; lst_i = (i == w.size() - 1); bytes_i = lastb;
         if (lst_i && chk_pos == 1) begin chk_val_i = 1; chk_dat_i = chk; end
         tick();
         val_i = 0; lst_i = 0; chk_val_i = 0;
         if (gaps && ($urandom % 3 == 0)) tick();
      end
      if (chk_pos == 2) begin
         val_i = 1; dat_i = $urandom; lst_i = 1; tick();
         val_i = 0; lst_i = 0;
         chk_val_i = 1; chk_dat_i = chk; tick(); chk_val_i = 0;
      end
      seen = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
         if (done_o) seen = 1; else tick();
      end
      check("done_wait", {31'd0, seen}, 32'd1);
      check("dat_final", dat_o, expd);
      val_i = 1; dat_i = $urandom; lst_i = 1; chk_val_i = 1; chk_dat_i = $urandom;
      tick();
      idle_inputs();
      tick();
      check("done_hold_dat", dat_o, expd);
      check("done_hold_done", {31'd0, done_o}, 32'd1);
   endtask

   initial begin
      logic [31:0] w[$];
      logic [31:0] r, c;
      logic [1:0] lb;
      idle_inputs();
      rstn = 0;
      repeat (2) tick();
      check("rst_val_o", {31'd0, val_o}, 32'd0);
      check("rst_done_o", {31'd0, done_o}, 32'd0);
      check("rst_err_o", {31'd0, err_o}, 32'd0);
      check("rst_dat_o", dat_o, 32'h00000001);
      rstn = 1; tick();

      val_i = 1; lst_i = 1; dat_i = 32'h12345678; chk_val_i = 1; chk_dat_i = 32'h1;
      tick(); idle_inputs(); tick();
      check("idle_ignore_dat", dat_o, 32'h00000001);
      check("idle_ignore_done", {31'd0, done_o}, 32'd0);

      w = '{32'h04090409};
      run_stream(w, 2'd3, 32'h0040001b, 0, 0);
      check("match_err", {31'd0, err_o}, 32'd0);
      run_stream(w, 2'd3, 32'h0040001c, 2, 0);
      check("mismatch_err", {31'd0, err_o}, 32'd1);

      // chk with last word: CMP entered on that edge, val_o one cycle later.
      do_start();
      sb_q.push_back({1'b0, 32'h0040001b});
      val_i = 1; lst_i = 1; dat_i = 32'h04090409; chk_val_i = 1; chk_dat_i = 32'h0040001b;
      @(posedge clk); #1;
      idle_inputs();
      check("lat_dat_step", dat_o, 32'h0040001b);
      check("lat_val_early", {31'd0, val_o}, 32'd0);
      @(posedge clk); #1;
      check("lat_val_pulse", {31'd0, val_o}, 32'd1);
      check("lat_done", {31'd0, done_o}, 32'd1);
      @(posedge clk); #1;
      check("lat_val_single", {31'd0, val_o}, 32'd0);
      tick();
      do_start();
      check("restart_done", {31'd0, done_o}, 32'd0);
      check("restart_err", {31'd0, err_o}, 32'd0);
      check("restart_dat", dat_o, 32'h00000001);

`ifdef ADLER32_CHK_PARTIAL_EN
      w = '{32'h61626300};
      run_stream(w, 2'd2, 32'h024d0127, 1, 0);
      check("partial_abc_err", {31'd0, err_o}, 32'd0);
      w = '{32'h61a5c3e7};
      run_stream(w, 2'd0, 32'h00620062, 2, 0);
      check("partial_a_dat", dat_o, 32'h00620062);
`endif

      // Async reset mid-stream drops partial sums and never produces val_o.
      do_start();
      for (int i = 0; i < 3; i++) begin
         val_i = 1; dat_i = $urandom; tick();
      end
      val_i = 0; chk_val_i = 1; chk_dat_i = 32'h0;
      @(posedge clk); #2;
      rstn = 0; #1;
      check("rst_mid_dat", dat_o, 32'h00000001);
      check("rst_mid_done", {31'd0, done_o}, 32'd0);
      idle_inputs();
      tick(); rstn = 1; tick();
      w = '{32'h04090409};
      run_stream(w, 2'd3, 32'h0040001b, 1, 0);
      check("post_rst_err", {31'd0, err_o}, 32'd0);

      for (int s = 0; s < 10; s++) begin
         byte unsigned bq[$];
         int n;
         w = {};
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) begin
            r = $urandom;
            w.push_back(r);
         end
         lb = 2'($urandom_range(0, 3));
         for (int i = 0; i < n; i++) begin
            int nb = 4;
`ifdef ADLER32_CHK_PARTIAL_EN
            if (i == n - 1) nb = int'(lb) + 1;
`endif
            for (int k = 0; k < nb; k++) bq.push_back(w[i][31-8*k -: 8]);
         end
         c = adler_ref(bq);
         if ($urandom % 2 == 0) c = c ^ (32'h1 << $urandom_range(0, 31));
         run_stream(w, lb, c, int'($urandom_range(0, 2)), 1);
      end

      w = {};
      for (int i = 0; i < 16384; i++) w.push_back(32'hFFFFFFFF);
      run_stream(w, 2'd3, 32'h77970EF2, 0, 0);
      check("wrap_err", {31'd0, err_o}, 32'd0);
      check("wrap_dat", dat_o, 32'h77970EF2);

      tick();
      check("invariant_below_mod", {31'd0, inv_bad}, 32'd0);
      check("sb_drained", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
